// File: rtl/bpu_if.sv
// bpu_if: fetch-lookup and branch-update bus of the next-fetch-PC predictor.
//   Fetch side : fetch_valid, fetch_pc, stall   -> predictor
//                pred_pc, npc, ifnpc_pdc, bpu_ready <- predictor
//   Update side: upd_valid, upd_br, upd_pc, upd_taken, upd_target -> predictor
//   master = fetch/execute pipeline, slave = predictor.
interface bpu_if;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        stall;
    logic [31:0] pred_pc;
    logic [31:0] npc;
    logic        ifnpc_pdc;
    logic        bpu_ready;
    logic        upd_valid;
    logic        upd_br;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;

    modport master (
        output fetch_valid, fetch_pc, stall,
        output upd_valid, upd_br, upd_pc, upd_taken, upd_target,
        input  pred_pc, npc, ifnpc_pdc, bpu_ready
    );

    modport slave (
        input  fetch_valid, fetch_pc, stall,
        input  upd_valid, upd_br, upd_pc, upd_taken, upd_target,
        output pred_pc, npc, ifnpc_pdc, bpu_ready
    );
endinterface

// File: rtl/bpu.sv
// bpu: direct-mapped BTB next-fetch-PC predictor for 8-byte fetch packets.
//   clk  : clock
//   rstn : asynchronous active-low reset
//   bus  : bpu_if.slave -- fetch lookup in, registered prediction out,
//          resolved-branch training in, bpu_ready out.
// Lookup result is registered (1-cycle latency) and frozen while stall is high.
// Valid bits are cleared by a 2^ENTRY_BITS-cycle INIT sweep after reset.
module bpu #(
    parameter int unsigned ENTRY_BITS = 6,
    parameter int unsigned TAG_BITS   = 8
) (
    input  logic clk,
    input  logic rstn,
    bpu_if.slave bus
);
    localparam int unsigned ENTRIES = 32'(1) << ENTRY_BITS;
    localparam int unsigned TAG_LO  = ENTRY_BITS + 3;
    localparam int unsigned TAG_HI  = TAG_BITS + ENTRY_BITS + 2;

    typedef enum logic {INIT, RUN} state_e;

    state_e                  state_q;
    logic [ENTRY_BITS-1:0]   cnt_q;
    logic                    ready_q;

    logic [ENTRIES-1:0]      valid_q;
    logic [TAG_BITS-1:0]     tag_q  [ENTRIES];
    logic [29:0]             tgt_q  [ENTRIES];
    logic                    slot_q [ENTRIES];
    logic [1:0]              ctr_q  [ENTRIES];

    logic [31:0]             pred_pc_q;
    logic [31:0]             npc_q;
    logic                    pdc_q;

    logic [ENTRY_BITS-1:0]   f_idx;
    logic [TAG_BITS-1:0]     f_tag;
    logic                    hit_d;
    logic [31:0]             npc_d;
    logic [ENTRY_BITS-1:0]   u_idx;
    logic [TAG_BITS-1:0]     u_tag;
    logic                    u_match;
    logic                    u_we;
    logic                    unused_bits;

    // INIT sweep counter and terminal RUN state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else if (state_q == INIT) begin
            cnt_q <= cnt_q + ENTRY_BITS'(1);
            if (cnt_q == ENTRY_BITS'(ENTRIES - 1)) begin
                state_q <= RUN;
                ready_q <= 1'b1;
            end
        end
    end

    // Lookup: taken prediction only for a strong-ish counter and a branch at or after the fetch slot
    always_comb begin
        f_idx = bus.fetch_pc[ENTRY_BITS+2:3];
        f_tag = bus.fetch_pc[TAG_HI:TAG_LO];
        hit_d = (state_q == RUN) && bus.fetch_valid && valid_q[f_idx] &&
                (tag_q[f_idx] == f_tag) && (slot_q[f_idx] >= bus.fetch_pc[2]) &&
                ctr_q[f_idx][1];
        npc_d = {bus.fetch_pc[31:3] + 29'd1, 3'b000};
        if (hit_d) begin
            npc_d = {tgt_q[f_idx], 2'b00};
        end
    end

    // Update match: slot is part of the match so the two slots of a packet do not alias
    always_comb begin
        u_idx   = bus.upd_pc[ENTRY_BITS+2:3];
        u_tag   = bus.upd_pc[TAG_HI:TAG_LO];
        u_match = valid_q[u_idx] && (tag_q[u_idx] == u_tag) && (slot_q[u_idx] == bus.upd_pc[2]);
        u_we    = (state_q == RUN) && bus.upd_valid && bus.upd_br;
    end

    // Valid bits: cleared by the sweep, set on allocation (no reset)
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            valid_q[cnt_q] <= 1'b0;
        end else if (u_we && bus.upd_taken && !u_match) begin
            valid_q[u_idx] <= 1'b1;
        end
    end

    // Entry payload training (no reset; gated by valid)
    always_ff @(posedge clk) begin
        if (u_we) begin
            if (u_match) begin
                if (bus.upd_taken) begin
                    ctr_q[u_idx] <= (ctr_q[u_idx] == 2'b11) ? 2'b11 : ctr_q[u_idx] + 2'd1;
                    tgt_q[u_idx] <= bus.upd_target[31:2];
                end else begin
                    ctr_q[u_idx] <= (ctr_q[u_idx] == 2'b00) ? 2'b00 : ctr_q[u_idx] - 2'd1;
                end
            end else if (bus.upd_taken) begin
                tag_q[u_idx]  <= u_tag;
                tgt_q[u_idx]  <= bus.upd_target[31:2];
                slot_q[u_idx] <= bus.upd_pc[2];
                ctr_q[u_idx]  <= 2'b10;
            end
        end
    end

    // Registered prediction, held during stall
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pred_pc_q <= '0;
            npc_q     <= '0;
            pdc_q     <= 1'b0;
        end else if (!bus.stall) begin
            pred_pc_q <= bus.fetch_pc;
            npc_q     <= npc_d;
            pdc_q     <= hit_d;
        end
    end

    assign bus.pred_pc   = pred_pc_q;
    assign bus.npc       = npc_q;
    assign bus.ifnpc_pdc = pdc_q;
    assign bus.bpu_ready = ready_q;

    // Address bits that do not take part in indexing or tagging
    assign unused_bits = ^{bus.fetch_pc[1:0], bus.upd_pc[1:0], bus.upd_pc[31:TAG_HI+1],
                           bus.upd_target[1:0]};
endmodule

// File: tb/tb_bpu.sv
// tb_bpu: scoreboard bench for bpu. Expected predictions are queued when a
// lookup is driven and compared against the registered outputs one cycle later.
module tb_bpu;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic        pdc;
    } exp_t;

    logic clk;
    logic rstn;
    int   checks;
    int   failures;
    exp_t exp_q[$];

    bpu_if bus();

    bpu dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Compare registered outputs against the oldest queued expectation
    task automatic pop_and_check(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_pred_pc"}, bus.pred_pc, e.pc);
            chk({tag, "_npc"}, bus.npc, e.npc);
            chk({tag, "_pdc"}, 32'(bus.ifnpc_pdc), 32'(e.pdc));
        end
    endtask

    // One lookup cycle; optional update presented on the same edge
    task automatic lookup(input string tag, input logic fv, input logic [31:0] pc,
                          input logic [31:0] e_npc, input logic e_pdc);
        exp_t e;
        bus.fetch_valid = fv;
        bus.fetch_pc    = pc;
        e.pc = pc; e.npc = e_npc; e.pdc = e_pdc;
        exp_q.push_back(e);
        @(posedge clk); #1;
        bus.upd_valid   = 1'b0;
        bus.fetch_valid = 1'b0;
        pop_and_check(tag);
    endtask

    task automatic set_upd(input logic br, input logic [31:0] pc, input logic taken,
                           input logic [31:0] tgt);
        bus.upd_valid  = 1'b1;
        bus.upd_br     = br;
        bus.upd_pc     = pc;
        bus.upd_taken  = taken;
        bus.upd_target = tgt;
    endtask

    task automatic upd(input logic br, input logic [31:0] pc, input logic taken,
                       input logic [31:0] tgt);
        set_upd(br, pc, taken, tgt);
        @(posedge clk); #1;
        bus.upd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        failures = 0;
        rstn = 1'b0;
        bus.fetch_valid = 1'b0; bus.fetch_pc = 32'h0; bus.stall = 1'b0;
        bus.upd_valid = 1'b0; bus.upd_br = 1'b0; bus.upd_pc = 32'h0;
        bus.upd_taken = 1'b0; bus.upd_target = 32'h0;
        #12;
        chk("rst_pred_pc", bus.pred_pc, 32'h0);
        chk("rst_npc", bus.npc, 32'h0);
        chk("rst_pdc", 32'(bus.ifnpc_pdc), 32'h0);
        chk("rst_ready", 32'(bus.bpu_ready), 32'h0);
        rstn = 1'b1;

        // INIT: sequential lookups, ready after exactly 64 edges, update dropped
        for (int c = 1; c <= 64; c++) begin
            if (c == 3) set_upd(1'b1, 32'h1C000304, 1'b1, 32'h1C000400);
            lookup("init_lookup", 1'b1, 32'h1C000000, 32'h1C000008, 1'b0);
            chk("init_ready", 32'(bus.bpu_ready), (c == 64) ? 32'd1 : 32'd0);
        end
        lookup("init_upd_dropped", 1'b1, 32'h1C000300, 32'h1C000308, 1'b0);

        // Allocation and prediction for both slots of the packet
        upd(1'b1, 32'h1C000104, 1'b1, 32'h1C000200);
        lookup("alloc_slot0", 1'b1, 32'h1C000100, 32'h1C000200, 1'b1);
        lookup("alloc_slot1", 1'b1, 32'h1C000104, 32'h1C000200, 1'b1);
        lookup("tag_miss", 1'b1, 32'h1C010100, 32'h1C010108, 1'b0);
        lookup("fv_low", 1'b0, 32'h1C000100, 32'h1C000108, 1'b0);

        // Counter hysteresis and target handling
        upd(1'b1, 32'h1C000104, 1'b0, 32'h0);
        lookup("hyst_ctr1", 1'b1, 32'h1C000100, 32'h1C000108, 1'b0);
        upd(1'b1, 32'h1C000104, 1'b1, 32'h1C000200);
        upd(1'b1, 32'h1C000104, 1'b1, 32'h1C000280);
        upd(1'b1, 32'h1C000104, 1'b0, 32'h1C000FF0);
        lookup("hyst_ctr2", 1'b1, 32'h1C000100, 32'h1C000280, 1'b1);
        upd(1'b1, 32'h1C000104, 1'b0, 32'h0);
        upd(1'b1, 32'h1C000104, 1'b0, 32'h0);
        upd(1'b1, 32'h1C000104, 1'b0, 32'h0);
        upd(1'b1, 32'h1C000104, 1'b1, 32'h1C000280);
        lookup("ctr_floor", 1'b1, 32'h1C000100, 32'h1C000108, 1'b0);

        // Slot rule: slot-0 branch is not predicted for a slot-1 fetch
        upd(1'b1, 32'h1C000100, 1'b1, 32'h1C000600);
        lookup("slot_after", 1'b1, 32'h1C000104, 32'h1C000108, 1'b0);
        lookup("slot_at", 1'b1, 32'h1C000100, 32'h1C000600, 1'b1);

        // Non-branch update ignored
        upd(1'b0, 32'h1C000400, 1'b1, 32'h1C000A00);
        lookup("nonbr_ignored", 1'b1, 32'h1C000400, 32'h1C000408, 1'b0);

        // Same-edge collision at index 5: no bypass
        set_upd(1'b1, 32'h1C000028, 1'b1, 32'h1C000800);
        lookup("collide_same", 1'b1, 32'h1C000028, 32'h1C000030, 1'b0);
        lookup("collide_next", 1'b1, 32'h1C000028, 32'h1C000800, 1'b1);

        // Address wrap
        lookup("wrap", 1'b1, 32'hFFFFFFF8, 32'h00000000, 1'b0);

        // Stall: outputs frozen, update during stall visible afterwards
        lookup("pre_stall", 1'b1, 32'h1C000000, 32'h1C000008, 1'b0);
        bus.stall = 1'b1;
        bus.fetch_valid = 1'b1;
        for (int s = 0; s < 3; s++) begin
            bus.fetch_pc = 32'h1C000010 + 32'(s) * 32'h10;
            if (s == 1) set_upd(1'b1, 32'h1C000048, 1'b1, 32'h1C000900);
            @(posedge clk); #1;
            bus.upd_valid = 1'b0;
            chk("stall_pred_pc", bus.pred_pc, 32'h1C000000);
            chk("stall_npc", bus.npc, 32'h1C000008);
            chk("stall_pdc", 32'(bus.ifnpc_pdc), 32'h0);
        end
        bus.stall = 1'b0;
        lookup("post_stall", 1'b1, 32'h1C000048, 32'h1C000900, 1'b1);

        // Mid-operation reset: async clear, full sweep, table empty afterwards
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_pred_pc", bus.pred_pc, 32'h0);
        chk("mid_rst_npc", bus.npc, 32'h0);
        chk("mid_rst_pdc", 32'(bus.ifnpc_pdc), 32'h0);
        chk("mid_rst_ready", 32'(bus.bpu_ready), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 1; c <= 64; c++) begin
            @(posedge clk); #1;
            if (c >= 63) chk("rerun_ready", 32'(bus.bpu_ready), (c == 64) ? 32'd1 : 32'd0);
        end
        lookup("rerun_cleared", 1'b1, 32'h1C000100, 32'h1C000108, 1'b0);
        lookup("rerun_cleared5", 1'b1, 32'h1C000028, 32'h1C000030, 1'b0);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
